// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-generic ALU with valid/ready handshakes on command and result.
// Single-cycle ops finish at the accept edge; shifts and multiply iterate one step per cycle.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero
);

    // One extra bit so the count can hold WIDTH for the multiply.
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        OP_SRA = 3'b000,
        OP_SRL = 3'b001,
        OP_SUB = 3'b010,
        OP_ADD = 3'b011,
        OP_SLL = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    state_e               state_r, state_s;
    op_e                  op_r, op_s;
    logic [WIDTH-1:0]     opa_r, opa_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [2*WIDTH-1:0]   acc_r, acc_s;
    logic [WIDTH-1:0]     res_r;
    logic                 carry_r;
    logic                 zero_r;

    logic                 load_s;
    logic [WIDTH-1:0]     res_load_s;
    logic                 carry_load_s;

    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sub_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_step_s;
    logic [WIDTH-1:0]     shift_step_s;
    logic                 accept_s;

    // Datapath building blocks shared by the next-state logic.
    always_comb begin
        add_s     = {1'b0, in_a} + {1'b0, in_b};
        sub_s     = {1'b0, in_a} - {1'b0, in_b};
        // Multiplier sits in the low half of acc; each step adds A to the upper half and shifts right.
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + (acc_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
        mul_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        case (op_r)
            OP_SRA:  shift_step_s = {opa_r[WIDTH-1], opa_r[WIDTH-1:1]};
            OP_SLL:  shift_step_s = {opa_r[WIDTH-2:0], 1'b0};
            default: shift_step_s = {1'b0, opa_r[WIDTH-1:1]};
        endcase
        accept_s = in_valid && (state_r == ST_IDLE);
    end

    // Next-state, operand capture and result-load decisions.
    always_comb begin
        state_s      = state_r;
        op_s         = op_r;
        opa_s        = opa_r;
        cnt_s        = cnt_r;
        acc_s        = acc_r;
        load_s       = 1'b0;
        res_load_s   = res_r;
        carry_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    op_s  = op_e'(op);
                    opa_s = in_a;
                    case (op_e'(op))
                        OP_SUB: begin
                            state_s      = ST_DONE;
                            load_s       = 1'b1;
                            res_load_s   = sub_s[WIDTH-1:0];
                            carry_load_s = sub_s[WIDTH];
                        end
                        OP_ADD: begin
                            state_s      = ST_DONE;
                            load_s       = 1'b1;
                            res_load_s   = add_s[WIDTH-1:0];
                            carry_load_s = add_s[WIDTH];
                        end
                        OP_AND: begin
                            state_s    = ST_DONE;
                            load_s     = 1'b1;
                            res_load_s = in_a & in_b;
                        end
                        OP_OR: begin
                            state_s    = ST_DONE;
                            load_s     = 1'b1;
                            res_load_s = in_a | in_b;
                        end
                        OP_MUL: begin
                            state_s = ST_BUSY;
                            cnt_s   = CNT_MUL;
                            acc_s   = {{WIDTH{1'b0}}, in_b};
                        end
                        default: begin
                            // Shifts: a zero amount completes immediately with A unchanged.
                            if (shamt == {SHW{1'b0}}) begin
                                state_s    = ST_DONE;
                                load_s     = 1'b1;
                                res_load_s = in_a;
                            end else begin
                                state_s = ST_BUSY;
                                cnt_s   = {1'b0, shamt};
                            end
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_s = cnt_r - CNT_ONE;
                if (op_r == OP_MUL) begin
                    acc_s = mul_step_s;
                    if (cnt_r == CNT_ONE) begin
                        state_s      = ST_DONE;
                        load_s       = 1'b1;
                        res_load_s   = mul_step_s[WIDTH-1:0];
                        carry_load_s = |mul_step_s[2*WIDTH-1:WIDTH];
                    end else begin
                        state_s = ST_BUSY;
                    end
                end else begin
                    opa_s = shift_step_s;
                    if (cnt_r == CNT_ONE) begin
                        state_s    = ST_DONE;
                        load_s     = 1'b1;
                        res_load_s = shift_step_s;
                    end else begin
                        state_s = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, iteration registers and held result; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= OP_SRA;
            opa_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            res_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            opa_r   <= opa_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            if (load_s) begin
                res_r   <= res_load_s;
                carry_r <= carry_load_s;
                zero_r  <= (res_load_s == {WIDTH{1'b0}});
            end
        end
    end

    // in_ready is gated by reset so a command presented during reset is never taken.
    assign in_ready   = (state_r == ST_IDLE) && !reset;
    assign out_valid  = (state_r == ST_DONE);
    assign out_result = res_r;
    assign out_carry  = carry_r;
    assign out_zero   = zero_r;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH = 8): results, flags, latency, backpressure and reset.
module tb_seq_alu;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_zero;

    int vectors;
    int miscompares;

    seq_alu #(.WIDTH(8), .SHW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .in_a       (in_a),
        .in_b       (in_b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, scramble inputs after accept, wait for out_valid (bounded).
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sh, output logic [7:0] res, output logic cy,
                          output logic z, output int lat);
        op = o; in_a = a; in_b = b; shamt = sh; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op = ~o; in_a = ~a; in_b = ~b; shamt = ~sh;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        res = out_result; cy = out_carry; z = out_zero;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; op = 3'b011; in_a = 8'h01; in_b = 8'h02;
        step();
        step();
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 8'h00 || out_carry !== 1'b0 || out_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b r=%h c=%b z=%b want 0/00/0/0",
                     out_valid, out_result, out_carry, out_zero);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready got=%b want=1", in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_dropped got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        logic [7:0] r; logic c; logic z; int l;
        run_op(3'b011, 8'hF0, 8'h20, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h10 || c !== 1'b1 || z !== 1'b0 || l !== 1) begin
            miscompares++;
            $display("FAIL add_carry got r=%h c=%b z=%b lat=%0d want 10/1/0/1", r, c, z, l);
        end
        drain();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL add_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        run_op(3'b011, 8'h01, 8'h02, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h03 || c !== 1'b0 || z !== 1'b0 || l !== 1) begin
            miscompares++;
            $display("FAIL add_small got r=%h c=%b z=%b lat=%0d want 03/0/0/1", r, c, z, l);
        end
        drain();
    endtask

    task automatic test_shift();
        logic [7:0] r; logic c; logic z; int l;
        run_op(3'b000, 8'h90, 8'h55, 3'd3, r, c, z, l);
        vectors++;
        if (r !== 8'hF2 || c !== 1'b0 || l !== 4) begin
            miscompares++;
            $display("FAIL sra3 got r=%h c=%b lat=%0d want F2/0/4", r, c, l);
        end
        drain();
        run_op(3'b001, 8'h90, 8'h55, 3'd3, r, c, z, l);
        vectors++;
        if (r !== 8'h12 || c !== 1'b0 || l !== 4) begin
            miscompares++;
            $display("FAIL srl3 got r=%h c=%b lat=%0d want 12/0/4", r, c, l);
        end
        drain();
        run_op(3'b100, 8'h81, 8'h00, 3'd1, r, c, z, l);
        vectors++;
        if (r !== 8'h02 || c !== 1'b0 || l !== 2) begin
            miscompares++;
            $display("FAIL sll1 got r=%h c=%b lat=%0d want 02/0/2", r, c, l);
        end
        drain();
        run_op(3'b000, 8'h90, 8'h00, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h90 || c !== 1'b0 || z !== 1'b0 || l !== 1) begin
            miscompares++;
            $display("FAIL sra0 got r=%h c=%b z=%b lat=%0d want 90/0/0/1", r, c, z, l);
        end
        drain();
    endtask

    task automatic test_logic_sub();
        logic [7:0] r; logic c; logic z; int l;
        run_op(3'b010, 8'h05, 8'h07, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'hFE || c !== 1'b1 || z !== 1'b0 || l !== 1) begin
            miscompares++;
            $display("FAIL sub_borrow got r=%h c=%b z=%b lat=%0d want FE/1/0/1", r, c, z, l);
        end
        drain();
        run_op(3'b010, 8'h07, 8'h07, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h00 || c !== 1'b0 || z !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_zero got r=%h c=%b z=%b want 00/0/1", r, c, z);
        end
        drain();
        run_op(3'b101, 8'hF0, 8'h3C, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h30 || c !== 1'b0 || z !== 1'b0 || l !== 1) begin
            miscompares++;
            $display("FAIL and got r=%h c=%b z=%b lat=%0d want 30/0/0/1", r, c, z, l);
        end
        drain();
        run_op(3'b110, 8'hF0, 8'h0F, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'hFF || c !== 1'b0 || z !== 1'b0 || l !== 1) begin
            miscompares++;
            $display("FAIL or got r=%h c=%b z=%b lat=%0d want FF/0/0/1", r, c, z, l);
        end
        drain();
    endtask

    task automatic test_mul();
        logic [7:0] r; logic c; logic z; int l;
        run_op(3'b111, 8'h0D, 8'h0B, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h8F || c !== 1'b0 || z !== 1'b0 || l !== 9) begin
            miscompares++;
            $display("FAIL mul_13x11 got r=%h c=%b z=%b lat=%0d want 8F/0/0/9", r, c, z, l);
        end
        drain();
        run_op(3'b111, 8'h10, 8'h10, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h00 || c !== 1'b1 || z !== 1'b1 || l !== 9) begin
            miscompares++;
            $display("FAIL mul_overflow got r=%h c=%b z=%b lat=%0d want 00/1/1/9", r, c, z, l);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [7:0] r; logic c; logic z; int l;
        int bad;
        run_op(3'b011, 8'h01, 8'h02, 3'd0, r, c, z, l);
        op = 3'b011; in_a = 8'h10; in_b = 8'h20; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || out_result !== 8'h03 || in_ready !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold got %0d bad cycles (last v=%b r=%h rdy=%b) want 0",
                     bad, out_valid, out_result, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 8'h30 || out_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next_cmd got v=%b r=%h c=%b want 1/30/0", out_valid, out_result, out_carry);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        logic [7:0] r; logic c; logic z; int l;
        int stale;
        op = 3'b111; in_a = 8'h0D; in_b = 8'h0B; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 8'h00 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset got v=%b r=%h rdy=%b want 0/00/1", out_valid, out_result, in_ready);
        end
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        vectors++;
        if (stale != 0) begin
            miscompares++;
            $display("FAIL no_stale got %0d valid cycles want 0", stale);
        end
        run_op(3'b011, 8'h01, 8'h02, 3'd0, r, c, z, l);
        vectors++;
        if (r !== 8'h03 || c !== 1'b0 || l !== 1) begin
            miscompares++;
            $display("FAIL post_reset_add got r=%h c=%b lat=%0d want 03/0/1", r, c, l);
        end
        drain();
    endtask

    // Test sequence.
    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; in_a = 8'h00; in_b = 8'h00; shamt = 3'd0;
        #1;
        test_reset();
        test_add();
        test_shift();
        test_logic_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
